// File: rtl/seq_mul_add_reconstructor.sv
// Shift-and-add multiply-accumulate: dividend = quotient * divisor + remainder.
// Rebuilds the dividend from the non-restoring divider's results.
module seq_mul_add_reconstructor #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   divisor,
  input  logic [WIDTH-1:0]   quotient,
  input  logic [WIDTH-1:0]   remainder,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] dividend
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] qr;
  logic [WIDTH-1:0] mr;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   sum;
  logic             load;
  logic             last;

  assign sum  = acc + (qr[0] ? {1'b0, mr} : '0);
  assign last = (cnt == CW'(1));

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // The addend preloaded into acc lands exactly in place after WIDTH shifts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      qr       <= '0;
      mr       <= '0;
      cnt      <= '0;
      dividend <= '0;
    end else if (load) begin
      acc <= {1'b0, remainder};
      qr  <= quotient;
      mr  <= divisor;
      cnt <= CNT_INIT;
    end else if (state == RUN) begin
      acc <= {1'b0, sum[WIDTH:1]};
      qr  <= {sum[0], qr[WIDTH-1:1]};
      cnt <= cnt - CW'(1);
      if (last) dividend <= {sum, qr[WIDTH-1:1]};
    end
  end

endmodule

// File: tb/tb_seq_mul_add_reconstructor.sv
// Bench for seq_mul_add_reconstructor: cycle model for WIDTH=4
// plus a WIDTH=8 corner instance.
module tb_seq_mul_add_reconstructor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] divisor, quotient, remainder;
  logic       busy, done;
  logic [7:0] dividend;

  logic        start8;
  logic [7:0]  divisor8, quotient8, remainder8;
  logic        busy8, done8;
  logic [15:0] dividend8;

  int vec_cnt;
  int err_cnt;
  bit run_cmp;

  seq_mul_add_reconstructor #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .divisor(divisor), .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done), .dividend(dividend)
  );

  seq_mul_add_reconstructor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8),
    .divisor(divisor8), .quotient(quotient8), .remainder(remainder8),
    .busy(busy8), .done(done8), .dividend(dividend8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an op accepted while idle yields M*Q+C after WIDTH edges.
  int         rem_cyc;
  logic [7:0] pend;
  logic [7:0] m_div;
  logic       m_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_cyc = 0;
      pend    = '0;
      m_div   = '0;
      m_done  = 1'b0;
    end else begin
      m_done = 1'b0;
      if (rem_cyc > 0) begin
        rem_cyc--;
        if (rem_cyc == 0) begin
          m_div  = pend;
          m_done = 1'b1;
        end
      end else if (start) begin
        pend    = 8'(int'(divisor) * int'(quotient) + int'(remainder));
        rem_cyc = 4;
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp && !rst) begin
      chk("busy", 32'(busy), 32'(rem_cyc > 0));
      chk("done", 32'(done), 32'(m_done));
      chk("dividend", 32'(dividend), 32'(m_div));
    end
  end

  task automatic start_op(input logic [3:0] m, input logic [3:0] q,
                          input logic [3:0] c);
    @(posedge clk);
    #1;
    divisor   = m;
    quotient  = q;
    remainder = c;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 20);
    chk("done_seen", 32'(done), 32'd1);
  endtask

  int n;
  int order[4096];

  initial begin
    vec_cnt   = 0;
    err_cnt   = 0;
    run_cmp   = 1'b0;
    rst       = 1'b1;
    start     = 1'b0;
    divisor   = '0;
    quotient  = '0;
    remainder = '0;
    start8    = 1'b0;
    divisor8  = '0;
    quotient8 = '0;
    remainder8 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dividend", 32'(dividend), 32'd0);
    run_cmp = 1'b1;

    start_op(4, 3, 1);
    wait_done(n);
    chk("lat_4x3+1", 32'(n), 32'd5);
    chk("val_4x3+1", 32'(dividend), 32'd13);
    chk("model_13", 32'(m_div), 32'd13);

    start_op(15, 15, 14);
    wait_done(n);
    chk("val_15x15+14", 32'(dividend), 32'hEF);
    chk("model_EF", 32'(m_div), 32'hEF);

    start_op(0, 9, 5);
    wait_done(n);
    chk("lat_0x9+5", 32'(n), 32'd5);
    chk("val_0x9+5", 32'(dividend), 32'd5);

    start_op(7, 0, 0);
    wait_done(n);
    chk("val_7x0+0", 32'(dividend), 32'd0);

    // Restart during a run is ignored; held start is taken on done.
    start_op(4, 3, 1);
    @(posedge clk);
    #1;
    divisor   = 9;
    quotient  = 9;
    remainder = 0;
    start     = 1'b1;
    wait_done(n);
    chk("ignored_restart", 32'(dividend), 32'd13);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n);
    chk("b2b_lat", 32'(n), 32'd5);
    chk("b2b_9x9", 32'(dividend), 32'd81);

    // Asynchronous abort mid-run.
    start_op(15, 15, 14);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_dividend", 32'(dividend), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end
    start_op(2, 3, 1);
    wait_done(n);
    chk("after_abort", 32'(dividend), 32'd7);

    // Wide instance corner.
    @(posedge clk);
    #1;
    divisor8   = 8'd255;
    quotient8  = 8'd255;
    remainder8 = 8'd254;
    start8     = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done8 && n < 30);
    chk("w8_lat", 32'(n), 32'd9);
    chk("w8_val", 32'(dividend8), 32'hFEFF);

    // Every operand triple in shuffled order, noisy inputs while running.
    for (int i = 0; i < 4096; i++) order[i] = i;
    for (int i = 4095; i > 0; i--) begin
      int j;
      int t;
      j = int'($urandom_range(i, 0));
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int k = 0; k < 4096; k++) begin
      logic [11:0] v;
      int cyc;
      v = 12'(order[k]);
      start_op(v[11:8], v[7:4], v[3:0]);
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
        if (done) begin
          start = 1'b0;
        end else begin
          start     = 1'($urandom_range(1, 0));
          divisor   = 4'($urandom);
          quotient  = 4'($urandom);
          remainder = 4'($urandom);
        end
      end while (!done && cyc < 20);
      chk("sweep_done", 32'(done), 32'd1);
    end

    run_cmp = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
